// File: rtl/button_reader_if.sv
// Push-button reader bus: the raw pin in, clean level and one-cycle events out.
interface button_reader_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;

  // Board/user side: drives the pin, consumes the events
  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press
  );

  // Reader side: samples the pin, produces the events
  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press
  );
endinterface

// File: rtl/button_reader.sv
// Push-button reader: synchronises and debounces one raw pin, then emits
// registered one-cycle press/release events and classifies each press as
// short (released before LONG_CYCLES) or long (held for LONG_CYCLES).
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 24000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  button_reader_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  // Pin level while the button is not pressed
  localparam logic PIN_RELEASED = ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE,
    DEB_P,
    HELD,
    LONG,
    DEB_R
  } state_t;

  logic [1:0]        sync_q;
  logic              s;
  state_t            state_q,     state_d;
  logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              level_q,     level_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              short_q,     short_d;
  logic              long_q,      long_d;
  logic [DEB_W-1:0]  deb_inc;
  logic [HOLD_W-1:0] hold_inc;

  // Two-flop synchroniser, preset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{PIN_RELEASED}};
    end else begin
      sync_q <= {sync_q[0], bus.btn_in};
    end
  end

  // Normalised pressed indicator
  assign s = sync_q[1] ^ PIN_RELEASED;

  // Saturating increments so neither counter can wrap
  assign deb_inc  = (deb_cnt_q  == DEB_MAX)  ? deb_cnt_q  : deb_cnt_q  + DEB_W'(1);
  assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  // Debounce / hold classification next-state and event logic
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d   = DEB_P;
          deb_cnt_d = DEB_W'(1);
        end
      end

      DEB_P: begin
        if (!s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      HELD: begin
        // Long threshold wins the event even if the pin falls this cycle
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = LONG;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
        end
        if (!s) begin
          state_d   = DEB_R;
          deb_cnt_d = DEB_W'(1);
        end else begin
          hold_cnt_d = hold_inc;
        end
      end

      LONG: begin
        if (!s) begin
          state_d   = DEB_R;
          deb_cnt_d = DEB_W'(1);
        end else begin
          hold_cnt_d = hold_inc;
        end
      end

      DEB_R: begin
        // Release bounce returns to the held state without a new press event
        if (s) begin
          state_d = long_flag_q ? LONG : HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          short_d   = !long_flag_q;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low pin. Every output is checked once per cycle against
// hand-derived event cycles (counted in clock edges after the pin change).
module tb_button_reader;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  button_reader_if bif ();

  button_reader #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Expected output vector {level, press, release, short, long}
  function automatic logic [4:0] ev(input bit lvl, input bit p, input bit r,
                                    input bit sh, input bit lg);
    return {lvl, p, r, sh, lg};
  endfunction

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bif.btn_level, bif.press_pulse, bif.release_pulse,
           bif.short_press, bif.long_press};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b (lvl,press,rel,short,long)",
             tag, obs, exp);
    end
  endtask

  // Advance one clock and check just after the edge
  task automatic cyc(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    bif.btn_in = 1'b1;

    // 1. Held in reset with the pin released: everything stays 0
    for (int c = 1; c <= 50; c++) cyc($sformatf("t1_rst c%0d", c), 5'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) cyc($sformatf("t1_idle c%0d", c), 5'b0);

    // 2. Short press: pin low for 10 cycles
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      cyc($sformatf("t2_short c%0d", c),
          ev(c >= 6 && c < 16, c == 6, c == 16, c == 16, 1'b0));
      if (c == 10) bif.btn_in = 1'b1;
    end

    // 3. Glitch of 3 cycles is rejected
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc($sformatf("t3_glitch c%0d", c), 5'b0);
      if (c == 3) bif.btn_in = 1'b1;
    end

    // 4. Long press: pin low for 40 cycles
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      cyc($sformatf("t4_long c%0d", c),
          ev(c >= 6 && c < 46, c == 6, c == 46, 1'b0, c == 26));
      if (c == 40) bif.btn_in = 1'b1;
    end

    // 5. Release bounce of 2 cycles returns to held without new events
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cyc($sformatf("t5_bounce c%0d", c),
          ev(c >= 6 && c < 22, c == 6, c == 22, c == 22, 1'b0));
      if (c == 8)  bif.btn_in = 1'b1;
      if (c == 10) bif.btn_in = 1'b0;
      if (c == 16) bif.btn_in = 1'b1;
    end

    // 6. Async reset while held, then the still-low pin is re-accepted
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 10; c++)
      cyc($sformatf("t6_pre c%0d", c), ev(c >= 6, c == 6, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 5'b0);
    cyc("t6_in_rst a", 5'b0);
    cyc("t6_in_rst b", 5'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc($sformatf("t6_post c%0d", c),
          ev(c >= 6 && c < 16, c == 6, c == 16, c == 16, 1'b0));
      if (c == 10) bif.btn_in = 1'b1;
    end

    // 7. Pin falls exactly as the long threshold is reached: reports long
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      cyc($sformatf("t7_edge_long c%0d", c),
          ev(c >= 6 && c < 29, c == 6, c == 29, 1'b0, c == 26));
      if (c == 23) bif.btn_in = 1'b1;
    end

    // 8. Pin falls one cycle before the threshold: reports short
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      cyc($sformatf("t8_edge_short c%0d", c),
          ev(c >= 6 && c < 28, c == 6, c == 28, c == 28, 1'b0));
      if (c == 22) bif.btn_in = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
